// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, address-width helper and register address type for regfile_sb
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    localparam int AW_DEF = addr_w(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write tracking, issue acceptance, read hazards and pending count
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_w(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] raddr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic              issue,
    input  logic [AW-1:0]     issue_addr,
    output logic              issue_ack,
    output logic [NRD-1:0]    rhaz,
    output logic [CW-1:0]     pend_cnt
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic             set;
    logic             clr;
    logic [CW-1:0]    cnt_nxt;

    // accept unless the target already has a producer that is not writing back now; clear then set so a reissue wins
    always_comb begin
        issue_ack = rst_n && (!issue || issue_addr == '0 || !pend[issue_addr] || (we && waddr == issue_addr));
        set       = issue && issue_ack && issue_addr != '0;
        clr       = we && waddr != '0 && pend[waddr];
        pend_nxt  = pend;
        if (clr) pend_nxt[waddr] = 1'b0;
        if (set) pend_nxt[issue_addr] = 1'b1;
        cnt_nxt   = pend_cnt + CW'(set) - CW'(clr);
    end

    // pending bits and their population count advance together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_haz
        logic [AW-1:0] a;
        assign a       = raddr[i*AW +: AW];
        assign rhaz[i] = a != '0 && pend[a] && !(BYPASS != 0 && we && waddr == a);
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with zero register, write bypass and pending-write scoreboard
module regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_w(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NRD*AW-1:0]   RADDR,
    output logic [NRD*XLEN-1:0] RDATA,
    output logic [NRD-1:0]      RHAZ,
    input  logic                WE,
    input  logic [AW-1:0]       WADDR,
    input  logic [XLEN-1:0]     WDATA,
    input  logic                ISSUE,
    input  logic [AW-1:0]       ISSUE_ADDR,
    output logic                ISSUE_ACK,
    output logic [CW-1:0]       PEND_CNT
);

    logic [XLEN-1:0] regs [NREGS];

    // data array; register 0 is never written so it stays at its reset value
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else if (WE && WADDR != '0) begin
            regs[WADDR] <= WDATA;
        end
    end

    // forwarding is gated by reset so reads return zero while reset is held
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          fwd;
        assign a   = RADDR[i*AW +: AW];
        assign fwd = BYPASS != 0 && RESET && WE && WADDR == a;
        assign RDATA[i*XLEN +: XLEN] = a == '0 ? '0 : fwd ? WDATA : regs[a];
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (CLK),
        .rst_n      (RESET),
        .raddr      (RADDR),
        .we         (WE),
        .waddr      (WADDR),
        .issue      (ISSUE),
        .issue_addr (ISSUE_ADDR),
        .issue_ack  (ISSUE_ACK),
        .rhaz       (RHAZ),
        .pend_cnt   (PEND_CNT)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb against an array/bit-set reference model
module tb_regfile_sb;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET;
    logic [9:0]  raddr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue;
    logic [4:0]  iaddr;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rhaz_a, rhaz_b;
    logic        ack_a, ack_b;
    logic [5:0]  cnt_a, cnt_b;

    logic [11:0]  raddr2;
    logic         we2;
    logic [3:0]   waddr2;
    logic [63:0]  wdata2;
    logic         issue2;
    logic [3:0]   iaddr2;
    logic [191:0] rdata2;
    logic [2:0]   rhaz2;
    logic         ack2;
    logic [4:0]   cnt2;

    regfile_sb u0 (
        .CLK(CLK), .RESET(RESET), .RADDR(raddr), .RDATA(rdata_a), .RHAZ(rhaz_a),
        .WE(we), .WADDR(waddr), .WDATA(wdata), .ISSUE(issue), .ISSUE_ADDR(iaddr),
        .ISSUE_ACK(ack_a), .PEND_CNT(cnt_a)
    );

    regfile_sb #(.BYPASS(0)) u1 (
        .CLK(CLK), .RESET(RESET), .RADDR(raddr), .RDATA(rdata_b), .RHAZ(rhaz_b),
        .WE(we), .WADDR(waddr), .WDATA(wdata), .ISSUE(issue), .ISSUE_ADDR(iaddr),
        .ISSUE_ACK(ack_b), .PEND_CNT(cnt_b)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) u2 (
        .CLK(CLK), .RESET(RESET), .RADDR(raddr2), .RDATA(rdata2), .RHAZ(rhaz2),
        .WE(we2), .WADDR(waddr2), .WDATA(wdata2), .ISSUE(issue2), .ISSUE_ADDR(iaddr2),
        .ISSUE_ACK(ack2), .PEND_CNT(cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem  [32];
    logic        pend [32];

    logic [3:0]  pa [3] = '{4'd1, 4'd2, 4'd15};
    logic [63:0] pv [3] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h8000000000000001};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mem[r]  = '0;
            pend[r] = 1'b0;
        end
    endtask

    task automatic idle();
        raddr = '0; we = 1'b0; waddr = '0; wdata = '0; issue = 1'b0; iaddr = '0;
    endtask

    function automatic int pend_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(pend[r]);
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(input int p, input bit byp);
        logic [4:0] a;
        a = raddr[p*5 +: 5];
        if (a == 0) return '0;
        if (byp && RESET && we && waddr == a) return wdata;
        return mem[a];
    endfunction

    function automatic logic exp_hz(input int p, input bit byp);
        logic [4:0] a;
        a = raddr[p*5 +: 5];
        return a != 0 && pend[a] && !(byp && RESET && we && waddr == a);
    endfunction

    function automatic logic exp_ack();
        if (!RESET) return 1'b0;
        return !issue || iaddr == 0 || !pend[iaddr] || (we && waddr == iaddr);
    endfunction

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    endfunction

    // check u0/u1 against the model with the inputs currently driven, then advance one cycle
    task automatic step();
        logic ack;
        #1;
        ack = exp_ack();
        chk("rdata_a0", rdata_a[31:0], exp_rd(0, 1'b1));
        chk("rdata_a1", rdata_a[63:32], exp_rd(1, 1'b1));
        chk("rdata_b0", rdata_b[31:0], exp_rd(0, 1'b0));
        chk("rdata_b1", rdata_b[63:32], exp_rd(1, 1'b0));
        chk("rhaz_a", rhaz_a, {exp_hz(1, 1'b1), exp_hz(0, 1'b1)});
        chk("rhaz_b", rhaz_b, {exp_hz(1, 1'b0), exp_hz(0, 1'b0)});
        chk("ack_a", ack_a, ack);
        chk("ack_b", ack_b, ack);
        chk("cnt_a", cnt_a, pend_count());
        chk("cnt_b", cnt_b, pend_count());
        @(posedge CLK);
        if (RESET) begin
            if (we && waddr != 0) begin
                mem[waddr]  = wdata;
                pend[waddr] = 1'b0;
            end
            if (issue && ack && iaddr != 0) pend[iaddr] = 1'b1;
        end
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0;
        idle();
        raddr2 = '0; we2 = 1'b0; waddr2 = '0; wdata2 = '0; issue2 = 1'b0; iaddr2 = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        step();

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        idle(); raddr = {5'd0, 5'd5};
        #1 chk("x5_written", rdata_a[31:0], 32'hDEADBEEF);
        step();
        issue = 1'b1; iaddr = 5'd4;
        step();

        idle(); raddr = {5'd0, 5'd5}; issue = 1'b1; iaddr = 5'd6;
        we = 1'b1; waddr = 5'd5; wdata = 32'hFFFFFFFF;
        RESET = 1'b0;
        model_reset();
        #1;
        chk("rst_x5", rdata_a[31:0], 32'h0);
        chk("rst_cnt", cnt_a, 6'd0);
        chk("rst_ack", ack_a, 1'b0);
        chk("rst_rhaz", rhaz_a, 2'b00);
        step();
        RESET = 1'b1;
        idle(); we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        step();
        idle(); raddr = {5'd0, 5'd5};
        #1 chk("x5_after_rst", rdata_a[31:0], 32'h00001234);
        step();

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = '0; issue = 1'b1; iaddr = 5'd0;
        #1;
        chk("x0_rd0", rdata_a[31:0], 32'h0);
        chk("x0_rd1", rdata_a[63:32], 32'h0);
        chk("x0_rhaz", rhaz_a, 2'b00);
        chk("x0_ack", ack_a, 1'b1);
        step();
        idle();
        #1 chk("x0_cnt", cnt_a, 6'd0);
        step();

        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        step();
        idle(); we = 1'b1; waddr = 5'd7; wdata = 32'hCAFEF00D; raddr = {5'd0, 5'd7};
        #1;
        chk("byp_on", rdata_a[31:0], 32'hCAFEF00D);
        chk("byp_off", rdata_b[31:0], 32'h11111111);
        step();

        idle(); issue = 1'b1; iaddr = 5'd3;
        step();
        idle(); raddr = {5'd0, 5'd3};
        #1;
        chk("x3_haz", rhaz_a[0], 1'b1);
        chk("x3_cnt", cnt_a, 6'd1);
        step();
        issue = 1'b1; iaddr = 5'd3;
        #1 chk("x3_waw", ack_a, 1'b0);
        step();
        idle(); we = 1'b1; waddr = 5'd3; wdata = 32'd33; raddr = {5'd0, 5'd3};
        #1 chk("x3_wb_haz", rhaz_a[0], 1'b0);
        step();
        idle(); raddr = {5'd0, 5'd3};
        #1;
        chk("x3_after_haz", rhaz_a[0], 1'b0);
        chk("x3_after_cnt", cnt_a, 6'd0);
        step();

        idle(); issue = 1'b1; iaddr = 5'd9;
        step();
        issue = 1'b1; iaddr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'd99;
        #1 chk("x9_ack", ack_a, 1'b1);
        step();
        idle(); raddr = {5'd0, 5'd9};
        #1;
        chk("x9_pend", rhaz_a[0], 1'b1);
        chk("x9_cnt", cnt_a, 6'd1);
        step();

        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 50) begin
                RESET = 1'b0;
                model_reset();
            end else begin
                RESET = 1'b1;
            end
            raddr = {rnd_addr(), rnd_addr()};
            we    = 1'($urandom);
            waddr = rnd_addr();
            wdata = $urandom;
            issue = 1'($urandom);
            iaddr = rnd_addr();
            step();
        end
        RESET = 1'b1;
        idle();

        issue2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iaddr2 = pa[k];
            #1 chk("p_ack", ack2, 1'b1);
            @(posedge CLK);
            @(negedge CLK);
        end
        issue2 = 1'b0;
        raddr2 = {pa[2], pa[1], pa[0]};
        #1;
        chk("p_cnt3", cnt2, 5'd3);
        chk("p_haz", rhaz2, 3'b111);
        @(posedge CLK);
        @(negedge CLK);
        we2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waddr2 = pa[k];
            wdata2 = pv[k];
            #1 chk("p_wb_haz", rhaz2[k], 1'b0);
            @(posedge CLK);
            @(negedge CLK);
        end
        we2 = 1'b0;
        #1;
        chk("p_cnt0", cnt2, 5'd0);
        chk("p_haz0", rhaz2, 3'b000);
        for (int k = 0; k < 3; k++) chk("p_data", rdata2[k*64 +: 64], pv[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the processor's integer register file.
- Provides configurable XLEN, register count and number of read ports.
- Adds a hardwired zero register, write-to-read bypass, and a per-register pending-write scoreboard that tracks in-flight producers and flags read hazards.
- Sits between ID (reads, issue) and WB (write-back) of the RV32IM pipeline.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of independent read ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = array value only
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  asynchronous, active-low reset
RADDR  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
RDATA  out  NRD*XLEN  packed read data, combinational
RHAZ  out  NRD  per-port hazard: operand not yet available
WE  in  1  write-back enable
WADDR  in  AW  write-back register
WDATA  in  XLEN  write-back data
ISSUE  in  1  request to mark ISSUE_ADDR pending (new producer)
ISSUE_ADDR  in  AW  destination register of issuing instruction
ISSUE_ACK  out  1  issue accepted this cycle (combinational)
PEND_CNT  out  $clog2(NREGS+1)  registered count of pending registers

Behaviour:
- Reset (RESET=0, asynchronous, any time including mid-operation):
  - all registers cleared to 0; all pending bits cleared; PEND_CNT=0.
  - RDATA therefore reads 0 on every port; RHAZ=0.
  - ISSUE_ACK=0 while RESET=0; ISSUE and WE are ignored.
- Register 0:
  - always reads 0; writes are discarded.
  - never becomes pending; ISSUE to register 0 is acked with no effect.
- Write: at posedge, if WE and WADDR!=0, reg[WADDR]<=WDATA.
- Read (combinational, per port i):
  - RADDR_i==0 -> 0.
  - else if BYPASS and WE and WADDR==RADDR_i -> WDATA.
  - else reg[RADDR_i].
- Scoreboard, pending bit per register:
  - ISSUE_ACK = RESET && (!ISSUE || ISSUE_ADDR==0 || !pend[ISSUE_ADDR] || (WE && WADDR==ISSUE_ADDR)).
    - One outstanding producer per register; a WAW issue is refused until the write-back cycle.
  - At posedge: if WE and WADDR!=0, clear pend[WADDR]. Then, if ISSUE and ISSUE_ACK and ISSUE_ADDR!=0, set pend[ISSUE_ADDR].
    - Set wins over clear when both hit the same register in one cycle.
  - WE to a non-pending register: plain write, scoreboard unchanged.
  - Refused ISSUE: no state change; the requester must hold ISSUE and ISSUE_ADDR until acked.
- RHAZ_i = RADDR_i!=0 && pend[RADDR_i] && !(BYPASS && WE && WADDR==RADDR_i).
  - An issue in the current cycle is not visible to RHAZ until the next cycle.
  - The issuing instruction's own source reads see the pre-issue state.
- PEND_CNT: registered.
  - Next value = current + set − clear, with the set/clear events from the same edge.
  - A same-cycle set+clear on one register nets 0.
  - Never exceeds NREGS−1.
- Latency:
  - read: 0 cycles.
  - write visible via array: next cycle.
  - write visible via bypass: same cycle.
  - pending set visible: next cycle.

Decomposition:
- Package rf_pkg:
  - constants XLEN_DEF=32, NREGS_DEF=32.
  - function addr_w(n) returning $clog2(n).
  - typedef reg_addr_t (logic [AW-1:0]).
- One sub-module: rf_scoreboard.
  - Contains the pending bit-vector, ISSUE_ACK, hazard lookup per port and PEND_CNT.
  - Instantiated once.
  - The data array and bypass muxing stay in regfile_sb.

Test Plan:
- Assert RESET=0 mid-stream after writing x5=0xDEADBEEF -> RDATA for x5 reads 0 immediately, PEND_CNT=0, ISSUE_ACK=0; release -> WE x5=0x1234 then read x5 next cycle = 0x00001234.
- WE=1 WADDR=0 WDATA=0xFFFFFFFF; read x0 on both ports -> 0, RHAZ=00; ISSUE x0 -> ISSUE_ACK=1, PEND_CNT stays 0.
- Bypass: WE x7=0xCAFEF00D, RADDR0=7 in the same cycle -> RDATA0=0xCAFEF00D (BYPASS=1). Repeat with BYPASS=0 -> old value of x7.
- Scoreboard: ISSUE x3 -> next cycle RHAZ for RADDR=3 =1, PEND_CNT=1. Second ISSUE x3 -> ISSUE_ACK=0. WE x3 with RADDR=3 -> RHAZ=0 that cycle; next cycle RHAZ=0, PEND_CNT=0.
- Same cycle ISSUE x9 (already pending) and WE x9 -> ISSUE_ACK=1; after the edge pend[9]=1, PEND_CNT unchanged.
- Parametrisation: NREGS=16, NRD=3, XLEN=64. Issue x1,x2,x15 -> PEND_CNT=3. Three ports read 1,2,15 -> RHAZ=111. Write back all three -> PEND_CNT=0 and 64-bit data read back exactly.
